// File: rtl/operand_fetch_unit.sv
// ID-stage operand fetch: regfile read addressing, EX/MEM/WB writer tag pipeline,
// operand forwarding, load-use stall detection and WB write-port sourcing.
module operand_fetch_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               id_wr_en,
  input  logic [RADDR_W-1:0] id_waddr,
  input  logic               id_is_load,
  input  logic               flush,
  output logic               id_ready,
  output logic [31:0]        raddr1,
  output logic [31:0]        raddr2,
  input  logic [31:0]        rdata1,
  input  logic [31:0]        rdata2,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic [DATA_W-1:0]  wb_wdata,
  output logic               wb_we,
  output logic [31:0]        wb_waddr,
  output logic [DATA_W-1:0]  opnd_a,
  output logic [DATA_W-1:0]  opnd_b,
  output logic [1:0]         fwd_sel_a,
  output logic [1:0]         fwd_sel_b,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned PadW = 32 - RADDR_W;

  // Only the EX tag needs is_load: a load reaching MEM is already forwardable.
  logic               ex_vld_q, mem_vld_q, wb_vld_q;
  logic [RADDR_W-1:0] ex_addr_q, mem_addr_q, wb_addr_q;
  logic               ex_ld_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic hazard;
  logic issue;

  function automatic logic tag_match(input logic vld, input logic [RADDR_W-1:0] addr,
                                     input logic [RADDR_W-1:0] s);
    return vld && (addr == s) && (s != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [RADDR_W-1:0] s,
                                         input logic ex_m, input logic mem_m, input logic wb_m);
    logic [1:0] sel;
    sel = 2'd0;
    if (used) begin
      if (ex_m)       sel = 2'd1;
      else if (mem_m) sel = 2'd2;
      else if (wb_m)  sel = 2'd3;
    end
    return sel;
  endfunction

  logic ex_m_a, mem_m_a, wb_m_a;
  logic ex_m_b, mem_m_b, wb_m_b;

  always_comb begin
    ex_m_a  = tag_match(ex_vld_q,  ex_addr_q,  id_rs);
    mem_m_a = tag_match(mem_vld_q, mem_addr_q, id_rs);
    wb_m_a  = tag_match(wb_vld_q,  wb_addr_q,  id_rs);
    ex_m_b  = tag_match(ex_vld_q,  ex_addr_q,  id_rt);
    mem_m_b = tag_match(mem_vld_q, mem_addr_q, id_rt);
    wb_m_b  = tag_match(wb_vld_q,  wb_addr_q,  id_rt);
  end

  assign hazard   = id_valid && ex_vld_q && ex_ld_q &&
                    ((id_rs_used && ex_m_a) || (id_rt_used && ex_m_b));
  assign id_ready = !hazard;
  assign issue    = id_valid && id_ready && !flush && id_wr_en && (id_waddr != '0);

  assign raddr1   = {{PadW{1'b0}}, id_rs};
  assign raddr2   = {{PadW{1'b0}}, id_rt};
  assign wb_we    = wb_vld_q;
  assign wb_waddr = {{PadW{1'b0}}, wb_addr_q};
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    fwd_sel_a = fwd_sel(id_rs_used, id_rs, ex_m_a, mem_m_a, wb_m_a);
    fwd_sel_b = fwd_sel(id_rt_used, id_rt, ex_m_b, mem_m_b, wb_m_b);
    unique case (fwd_sel_a)
      2'd1:    opnd_a = ex_result;
      2'd2:    opnd_a = mem_result;
      2'd3:    opnd_a = wb_wdata;
      default: opnd_a = DATA_W'(rdata1);
    endcase
    unique case (fwd_sel_b)
      2'd1:    opnd_b = ex_result;
      2'd2:    opnd_b = mem_result;
      2'd3:    opnd_b = wb_wdata;
      default: opnd_b = DATA_W'(rdata2);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q    <= 1'b0;
      ex_addr_q   <= '0;
      ex_ld_q     <= 1'b0;
      mem_vld_q   <= 1'b0;
      mem_addr_q  <= '0;
      wb_vld_q    <= 1'b0;
      wb_addr_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_vld_q   <= mem_vld_q;
      wb_addr_q  <= mem_addr_q;
      mem_vld_q  <= ex_vld_q;
      mem_addr_q <= ex_addr_q;
      ex_vld_q   <= issue;
      ex_addr_q  <= issue ? id_waddr : '0;
      ex_ld_q    <= issue && id_is_load;
      if (hazard && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed table-driven bench for operand_fetch_unit, plus stall saturation and async reset.
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
  logic [4:0]  id_rs, id_rt, id_waddr;
  logic        id_ready, wb_we;
  logic [31:0] raddr1, raddr2, rdata1, rdata2, ex_result, mem_result, wb_wdata;
  logic [31:0] wb_waddr, opnd_a, opnd_b;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [3:0]  stall_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  operand_fetch_unit #(.DATA_W(32), .RADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
    .id_waddr(id_waddr), .id_is_load(id_is_load), .flush(flush), .id_ready(id_ready),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .ex_result(ex_result), .mem_result(mem_result), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .opnd_a(opnd_a), .opnd_b(opnd_b), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic v; logic [4:0] rs; logic [4:0] rt; logic ru; logic tu; logic we;
    logic [4:0] wa; logic ld; logic fl;
    logic [31:0] r1; logic [31:0] r2; logic [31:0] exr; logic [31:0] memr; logic [31:0] wbd;
    logic rdy; logic [1:0] sa; logic [1:0] sb; logic [31:0] oa; logic [31:0] ob;
    logic wwe; logic [4:0] wwa; logic [3:0] cnt; logic chk;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ru, input logic tu, input logic we, input logic [4:0] wa,
                       input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = ru; id_rt_used = tu;
    id_wr_en = we; id_waddr = wa; id_is_load = ld; flush = fl;
  endtask

  initial begin
    int model_cnt;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rdata1 = 32'h100; rdata2 = 32'h200;
    ex_result = 32'hE0; mem_result = 32'hD0; wb_wdata = 32'hB0;

    // v rs rt ru tu we wa ld fl | r1 r2 exr memr wbd | rdy sa sb oa ob wwe wwa cnt chk
    vecs[0]  = '{1,0,0,0,0,1,3,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,0,1};
    vecs[1]  = '{1,3,0,1,0,0,0,0,0, 'h100,'h200,'h11,'hD0,'hB0, 1,1,0,'h11,'h200, 0,0,0,1};
    vecs[2]  = '{1,3,0,1,0,0,0,0,0, 'h100,'h200,'h99,'h11,'hB0, 1,2,0,'h11,'h200, 0,0,0,1};
    vecs[3]  = '{1,3,0,1,0,0,0,0,0, 'h100,'h200,'h99,'h55,'h11, 1,3,0,'h11,'h200, 1,3,0,1};
    vecs[4]  = '{1,0,0,0,0,1,5,1,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,0,1};
    vecs[5]  = '{1,0,5,0,1,1,6,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 0,0,0,'h100,'h200, 0,0,0,0};
    vecs[6]  = '{1,0,5,0,1,1,6,0,0, 'h100,'h200,'hE0,'hDEADBEEF,'hB0,
                 1,0,2,'h100,'hDEADBEEF, 0,0,1,1};
    vecs[7]  = '{1,0,0,0,0,1,7,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 1,5,1,1};
    vecs[8]  = '{0,0,0,0,0,0,0,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,1,1};
    vecs[9]  = '{1,0,0,0,0,1,7,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 1,6,1,1};
    vecs[10] = '{1,7,0,1,0,0,0,0,0, 'h100,'h200,'hAA,'h33,'hBB, 1,1,0,'hAA,'h200, 1,7,1,1};
    vecs[11] = '{1,7,0,1,0,0,0,0,0, 'h100,'h200,'hE0,'h44,'hB0, 1,2,0,'h44,'h200, 0,0,1,1};
    vecs[12] = '{1,7,0,1,0,0,0,0,0, 'h1234,'h200,'hE0,'hD0,'hBB, 1,3,0,'hBB,'h200, 1,7,1,1};
    vecs[13] = '{1,0,0,1,1,1,0,0,0, 'h0,'h0,'hE0,'hD0,'hB0, 1,0,0,'h0,'h0, 0,0,1,1};
    vecs[14] = '{1,0,0,1,0,0,0,0,0, 'h0,'h200,'hE0,'hD0,'hB0, 1,0,0,'h0,'h200, 0,0,1,1};
    vecs[15] = '{0,0,0,0,0,0,0,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,1,1};
    vecs[16] = '{0,0,0,0,0,0,0,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,1,1};
    vecs[17] = '{1,9,0,1,0,1,9,0,1, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,1,1};
    vecs[18] = '{0,9,0,1,0,0,0,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,1,1};
    vecs[19] = '{0,9,0,1,0,0,0,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,1,1};
    vecs[20] = '{0,9,0,1,0,0,0,0,0, 'h100,'h200,'hE0,'hD0,'hB0, 1,0,0,'h100,'h200, 0,0,1,1};

    #3 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].ru, vecs[i].tu, vecs[i].we,
            vecs[i].wa, vecs[i].ld, vecs[i].fl);
      rdata1 = vecs[i].r1; rdata2 = vecs[i].r2;
      ex_result = vecs[i].exr; mem_result = vecs[i].memr; wb_wdata = vecs[i].wbd;
      #1;
      chk($sformatf("v%0d id_ready", i), 32'(id_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d wb_we", i), 32'(wb_we), 32'(vecs[i].wwe));
      if (vecs[i].wwe) chk($sformatf("v%0d wb_waddr", i), wb_waddr, 32'(vecs[i].wwa));
      chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d raddr1", i), raddr1, {27'b0, vecs[i].rs});
      chk($sformatf("v%0d raddr2", i), raddr2, {27'b0, vecs[i].rt});
      if (vecs[i].chk) begin
        chk($sformatf("v%0d fwd_sel_a", i), 32'(fwd_sel_a), 32'(vecs[i].sa));
        chk($sformatf("v%0d fwd_sel_b", i), 32'(fwd_sel_b), 32'(vecs[i].sb));
        chk($sformatf("v%0d opnd_a", i), opnd_a, vecs[i].oa);
        chk($sformatf("v%0d opnd_b", i), opnd_b, vecs[i].ob);
      end
      tick();
    end

    // Repeated load/use pairs drive the 4-bit counter into saturation.
    model_cnt = 1;
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 1, 0);
      tick();
      drive(1, 0, 5, 0, 1, 0, 0, 0, 0);
      #1;
      chk($sformatf("sat%0d id_ready", k), 32'(id_ready), 32'd0);
      tick();
      model_cnt = (model_cnt < 15) ? model_cnt + 1 : 15;
      chk($sformatf("sat%0d stall_cnt", k), 32'(stall_cnt), 32'(model_cnt));
    end

    // Writers in flight, then asynchronous reset away from any clock edge.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 1, 4, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst wb_we", 32'(wb_we), 32'd1);
    chk("pre_rst wb_waddr", wb_waddr, 32'd4);
    chk("pre_rst stall_cnt", 32'(stall_cnt), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst wb_we", 32'(wb_we), 32'd0);
    chk("async_rst stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async_rst id_ready", 32'(id_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst wb_we", 32'(wb_we), 32'd0);
    tick();
    chk("post_rst2 wb_we", 32'(wb_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
